// File: rtl/z80_bridge_pkg.sv
// Shared types and constants for the Z80-to-GPU-RAM bus bridge.
package z80_bridge_pkg;

  // Read sequencer states
  typedef enum logic [2:0] {
    StIdle,
    StRdDrain,
    StRdReq,
    StRdWait,
    StRdDrive
  } rd_state_e;

  // I/O port that returns bridge status when the status feature is built in
  localparam logic [7:0] StatusPort  = 8'hF0;
  // Data returned to the Z80 when a GPU read times out
  localparam logic [7:0] TimeoutData = 8'hFF;

endpackage

// File: rtl/z80_bridge_wfifo.sv
// Posted-write FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate counter. Depth is a power of 2.
module z80_bridge_wfifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign rdata_o = mem_q[rptr_q[Aw-1:0]];

  // Pointer update; push when full and pop when empty are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + (Aw + 1)'(1);
      if (pop_i && !empty_o) rptr_q <= rptr_q + (Aw + 1)'(1);
    end
  end

  // Storage; contents are meaningless after reset since the pointers are cleared
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/z80_bus_bridge_v2.sv
// Z80 bus to GPU RAM bridge with posted writes and stalled, time-limited reads.
// Optional feature macro: Z80_BRIDGE_IO_STATUS_EN (I/O read of the status port).
module z80_bus_bridge_v2
  import z80_bridge_pkg::*;
#(
  parameter int unsigned          ADDR_W       = 22,
  parameter int unsigned          WIN_BITS     = 3,
  parameter logic [WIN_BITS-1:0]  WIN_BASE     = 3'b011,
  parameter int unsigned          GPU_ADDR_W   = 20,
  parameter int unsigned          SYNC_STAGES  = 2,
  parameter int unsigned          DELAY_CYCLES = 2,
  parameter int unsigned          WFIFO_DEPTH  = 4,
  parameter int unsigned          RD_TIMEOUT   = 255
) (
  input  logic                  GPU_CLK,
  input  logic                  reset,
  input  logic                  Z80_CLK,
  input  logic                  Z80_M1n,
  input  logic                  Z80_MREQn,
  input  logic                  Z80_WRn,
  input  logic                  Z80_RDn,
  input  logic                  Z80_IORQn,
  input  logic [ADDR_W-1:0]     Z80_addr,
  input  logic [7:0]            Z80_wData,
  input  logic [7:0]            gpu_rData,
  input  logic                  gpu_rd_rdy,
  output logic                  gpu_wr_ena,
  output logic [GPU_ADDR_W-1:0] gpu_addr,
  output logic [7:0]            gpu_wdata,
  output logic                  gpu_rd_req,
  output logic [7:0]            Z80_rData,
  output logic                  Z80_rData_ena,
  output logic                  Z80_245data_dir,
  output logic                  Z80_245_oe,
  output logic                  Z80_WAITn,
  output logic                  rd_timeout
);

  localparam int unsigned LowW  = ADDR_W - WIN_BITS;
  localparam int unsigned FifoW = GPU_ADDR_W + 8;
  localparam int unsigned DlyW  = $clog2(DELAY_CYCLES + 1);
  localparam int unsigned TmoW  = $clog2(RD_TIMEOUT + 1);
  // Strobe vector order: {clk, m1, mreq, wr, rd, iorq}; strobes idle high
  localparam logic [5:0]  StrbRst = 6'b011111;

  logic [5:0] strb_in, cur, prev_q;
  logic [5:0] sync_q [SYNC_STAGES];

  assign strb_in = {Z80_CLK, Z80_M1n, Z80_MREQn, Z80_WRn, Z80_RDn, Z80_IORQn};
  assign cur     = sync_q[SYNC_STAGES-1];

  // Synchronise Z80 strobes and keep the previous synchronised value for edges
  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= StrbRst;
      prev_q <= StrbRst;
    end else begin
      sync_q[0] <= strb_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= cur;
    end
  end

  logic                  win_hit, mem_cyc, wr_fall, wr_rise, rd_fall, rd_rise, z80clk_rise;
  logic [GPU_ADDR_W-1:0] z80_gaddr;

  assign win_hit     = (Z80_addr[ADDR_W-1 -: WIN_BITS] == WIN_BASE);
  assign mem_cyc     = !cur[3] && cur[4] && win_hit;
  assign wr_fall     = prev_q[2] && !cur[2] && mem_cyc;
  assign wr_rise     = !prev_q[2] && cur[2];
  assign rd_fall     = prev_q[1] && !cur[1] && mem_cyc;
  assign rd_rise     = !prev_q[1] && cur[1];
  assign z80clk_rise = cur[5] && !prev_q[5];
  assign z80_gaddr   = GPU_ADDR_W'(Z80_addr[LowW-1:0]);

`ifdef Z80_BRIDGE_IO_STATUS_EN
  logic io_fall;
  assign io_fall = prev_q[1] && !cur[1] && !cur[0] && cur[4] && (Z80_addr[7:0] == StatusPort);
`endif

  // Bus clock edge and, without the status port, IORQ carry no function here
  logic unused_strb;
  assign unused_strb = ^{z80clk_rise, cur[0], prev_q[0]};

  rd_state_e        state_q;
  logic             fifo_full, fifo_empty, push, pop;
  logic [FifoW-1:0] fifo_rdata, hold_q;
  logic             hold_vld_q, wdly_run_q, wr_stall_q;
  logic [DlyW-1:0]  wdly_q;

  assign push = hold_vld_q && !fifo_full;
  // The GPU port belongs to the read while the request is outstanding
  assign pop  = !fifo_empty && (state_q != StRdReq) && (state_q != StRdWait);

  z80_bridge_wfifo #(
    .Width (FifoW),
    .Depth (WFIFO_DEPTH)
  ) u_wfifo (
    .clk_i   (GPU_CLK),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (hold_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Write capture: wait for address/data to settle, hold the sample until the FIFO
  // takes it. Capture is not gated by the read sequencer; an overlapping write is a
  // bus violation that simply backs up behind the stalled read.
  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      wdly_q     <= '0;
      wdly_run_q <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      wr_stall_q <= 1'b0;
    end else begin
      if (wr_fall) begin
        wdly_run_q <= 1'b1;
        wdly_q     <= DlyW'(DELAY_CYCLES);
      end else if (wdly_run_q) begin
        if (wdly_q == DlyW'(1)) wdly_run_q <= 1'b0;
        else                    wdly_q     <= wdly_q - DlyW'(1);
      end
      if (wdly_run_q && (wdly_q == DlyW'(1))) begin
        hold_q     <= {z80_gaddr, Z80_wData};
        hold_vld_q <= 1'b1;
      end else if (push) begin
        hold_vld_q <= 1'b0;
      end
      wr_stall_q <= hold_vld_q && fifo_full;
    end
  end

  logic                  gpu_wr_ena_q, gpu_rd_req_q, rdata_ena_q, dir_q, oe_q;
  logic                  rd_waitn_q, rd_tmo_q, wr_act_q;
  logic [GPU_ADDR_W-1:0] gpu_addr_q;
  logic [7:0]            gpu_wdata_q, rdata_q;
  logic [TmoW-1:0]       tmo_cnt_q;

  // Read sequencer, FIFO drain onto the GPU port, and 245/WAITn control
  always_ff @(posedge GPU_CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      gpu_wr_ena_q <= 1'b0;
      gpu_addr_q   <= '0;
      gpu_wdata_q  <= '0;
      gpu_rd_req_q <= 1'b0;
      rdata_q      <= '0;
      rdata_ena_q  <= 1'b0;
      dir_q        <= 1'b1;
      oe_q         <= 1'b0;
      rd_waitn_q   <= 1'b1;
      rd_tmo_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      wr_act_q     <= 1'b0;
    end else begin
      gpu_wr_ena_q <= pop;
      gpu_rd_req_q <= 1'b0;
      if (pop) begin
        gpu_addr_q  <= fifo_rdata[FifoW-1 -: GPU_ADDR_W];
        gpu_wdata_q <= fifo_rdata[7:0];
      end
      unique case (state_q)
        StIdle: begin
          if (rd_fall) begin
            state_q    <= StRdDrain;
            rd_waitn_q <= 1'b0;
            dir_q      <= 1'b0;
            oe_q       <= 1'b1;
`ifdef Z80_BRIDGE_IO_STATUS_EN
          end else if (io_fall) begin
            state_q     <= StRdDrive;
            rdata_q     <= {rd_tmo_q, fifo_full, fifo_empty, 5'b0};
            rdata_ena_q <= 1'b1;
            dir_q       <= 1'b0;
            oe_q        <= 1'b1;
`endif
          end else if (wr_fall) begin
            oe_q     <= 1'b1;
            wr_act_q <= 1'b1;
          end else if (wr_rise && wr_act_q) begin
            oe_q     <= 1'b0;
            wr_act_q <= 1'b0;
          end
        end
        // Posted writes must reach RAM before the read for ordering
        StRdDrain: begin
          if (fifo_empty) begin
            state_q      <= StRdReq;
            gpu_rd_req_q <= 1'b1;
            gpu_addr_q   <= z80_gaddr;
          end
        end
        StRdReq: begin
          state_q   <= StRdWait;
          tmo_cnt_q <= '0;
        end
        StRdWait: begin
          if (gpu_rd_rdy) begin
            state_q     <= StRdDrive;
            rdata_q     <= gpu_rData;
            rdata_ena_q <= 1'b1;
            rd_waitn_q  <= 1'b1;
          end else if (tmo_cnt_q == TmoW'(RD_TIMEOUT)) begin
            state_q     <= StRdDrive;
            rdata_q     <= TimeoutData;
            rdata_ena_q <= 1'b1;
            rd_waitn_q  <= 1'b1;
            rd_tmo_q    <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StRdDrive: begin
          if (rd_rise) begin
            state_q     <= StIdle;
            rdata_ena_q <= 1'b0;
            oe_q        <= 1'b0;
            dir_q       <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gpu_wr_ena      = gpu_wr_ena_q;
  assign gpu_addr        = gpu_addr_q;
  assign gpu_wdata       = gpu_wdata_q;
  assign gpu_rd_req      = gpu_rd_req_q;
  assign Z80_rData       = rdata_q;
  assign Z80_rData_ena   = rdata_ena_q;
  assign Z80_245data_dir = dir_q;
  assign Z80_245_oe      = oe_q;
  assign Z80_WAITn       = rd_waitn_q && !wr_stall_q;
  assign rd_timeout      = rd_tmo_q;

endmodule

// File: tb/tb_z80_bus_bridge_v2.sv
// Scoreboard bench for z80_bus_bridge_v2: stimulus queues expected GPU writes,
// read requests and read data; a negedge monitor pops and compares them.
module tb_z80_bus_bridge_v2;

  logic        GPU_CLK = 1'b0, reset = 1'b0, Z80_CLK = 1'b0;
  logic        Z80_M1n = 1'b1, Z80_MREQn = 1'b1, Z80_WRn = 1'b1, Z80_RDn = 1'b1;
  logic        Z80_IORQn = 1'b1;
  logic [21:0] Z80_addr = '0;
  logic [7:0]  Z80_wData = '0;
  logic        rdy_auto = 1'b0, rdy_man = 1'b0;
  logic [7:0]  rdat_auto = '0, rdat_man = '0;
  logic        gpu_rd_rdy;
  logic [7:0]  gpu_rData;
  logic        gpu_wr_ena, gpu_rd_req, Z80_rData_ena, Z80_245data_dir, Z80_245_oe;
  logic        Z80_WAITn, rd_timeout;
  logic [19:0] gpu_addr;
  logic [7:0]  gpu_wdata, Z80_rData;

  assign gpu_rd_rdy = rdy_auto | rdy_man;
  assign gpu_rData  = rdy_man ? rdat_man : rdat_auto;

  z80_bus_bridge_v2 dut (
    .GPU_CLK         (GPU_CLK),
    .reset           (reset),
    .Z80_CLK         (Z80_CLK),
    .Z80_M1n         (Z80_M1n),
    .Z80_MREQn       (Z80_MREQn),
    .Z80_WRn         (Z80_WRn),
    .Z80_RDn         (Z80_RDn),
    .Z80_IORQn       (Z80_IORQn),
    .Z80_addr        (Z80_addr),
    .Z80_wData       (Z80_wData),
    .gpu_rData       (gpu_rData),
    .gpu_rd_rdy      (gpu_rd_rdy),
    .gpu_wr_ena      (gpu_wr_ena),
    .gpu_addr        (gpu_addr),
    .gpu_wdata       (gpu_wdata),
    .gpu_rd_req      (gpu_rd_req),
    .Z80_rData       (Z80_rData),
    .Z80_rData_ena   (Z80_rData_ena),
    .Z80_245data_dir (Z80_245data_dir),
    .Z80_245_oe      (Z80_245_oe),
    .Z80_WAITn       (Z80_WAITn),
    .rd_timeout      (rd_timeout)
  );

  always #4 GPU_CLK = ~GPU_CLK;
  always #62 Z80_CLK = ~Z80_CLK;

  int checks = 0, errors = 0, cyc = 0, req_cyc = 0;
  logic [27:0] exp_wr[$];
  logic [19:0] exp_rd[$];
  logic [7:0]  exp_rdat[$];
  logic [7:0]  gmem [int];
  bit gpu_auto = 1'b1, req_seen = 1'b0, waitn_low_seen = 1'b0, oe_seen = 1'b0, ena_seen = 1'b0;
  logic ena_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge GPU_CLK);
  endtask

  // Monitor: compares every GPU strobe and every read return with the queues
  always @(negedge GPU_CLK) begin
    cyc++;
    if (!Z80_WAITn) waitn_low_seen = 1'b1;
    if (Z80_245_oe) oe_seen = 1'b1;
    if (Z80_rData_ena) ena_seen = 1'b1;
    if (gpu_wr_ena) begin
      gmem[int'(gpu_addr)] = gpu_wdata;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL gpu_write_unexpected: got %0h expected none", {gpu_addr, gpu_wdata});
      end else chk("gpu_write", {gpu_addr, gpu_wdata}, exp_wr.pop_front());
    end
    if (gpu_rd_req) begin
      req_seen = 1'b1;
      req_cyc  = cyc;
      chk("rd_req_writes_pending", exp_wr.size(), 0);
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_req_unexpected: got %0h expected none", gpu_addr);
      end else chk("rd_req_addr", gpu_addr, exp_rd.pop_front());
    end
    if (Z80_rData_ena && !ena_prev) begin
      if (exp_rdat.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_data_unexpected: got %0h expected none", Z80_rData);
      end else chk("rd_data", Z80_rData, exp_rdat.pop_front());
    end
    ena_prev = Z80_rData_ena;
  end

  // GPU RAM model: answers a request three cycles later when enabled
  initial begin
    int a;
    forever begin
      @(negedge GPU_CLK);
      if (gpu_auto && gpu_rd_req) begin
        a = int'(gpu_addr);
        tick(3);
        rdat_auto = gmem.exists(a) ? gmem[a] : 8'hA5;
        rdy_auto  = 1'b1;
        @(negedge GPU_CLK);
        rdy_auto  = 1'b0;
      end
    end
  end

  task automatic z80_write(input logic [21:0] a, input logic [7:0] d, input bit chk_oe,
                           input bit exp_oe, input bit rel_mreq);
    @(negedge GPU_CLK);
    Z80_addr = a; Z80_wData = d; Z80_MREQn = 1'b0; Z80_WRn = 1'b0;
    tick(7);
    if (chk_oe) chk("wr_oe_during", Z80_245_oe, exp_oe);
    Z80_WRn = 1'b1;
    if (rel_mreq) Z80_MREQn = 1'b1;
    tick(5);
    if (chk_oe) chk("wr_oe_after", Z80_245_oe, 0);
  endtask

  task automatic wait_ena(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge GPU_CLK);
      if (Z80_rData_ena) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic z80_read(input logic [21:0] a, output bit ok);
    @(negedge GPU_CLK);
    Z80_addr = a; Z80_MREQn = 1'b0; Z80_RDn = 1'b0;
    wait_ena(600, ok);
  endtask

  task automatic z80_read_end();
    Z80_RDn = 1'b1; Z80_MREQn = 1'b1;
    tick(6);
    chk("rd_end_oe", Z80_245_oe, 0);
    chk("rd_end_dir", Z80_245data_dir, 1);
    chk("rd_end_ena", Z80_rData_ena, 0);
    chk("rd_end_waitn", Z80_WAITn, 1);
  endtask

  task automatic chk_reset();
    chk("rst_wr_ena", gpu_wr_ena, 0);
    chk("rst_gpu_addr", gpu_addr, 0);
    chk("rst_gpu_wdata", gpu_wdata, 0);
    chk("rst_rd_req", gpu_rd_req, 0);
    chk("rst_rdata", Z80_rData, 0);
    chk("rst_rdata_ena", Z80_rData_ena, 0);
    chk("rst_dir", Z80_245data_dir, 1);
    chk("rst_oe", Z80_245_oe, 0);
    chk("rst_waitn", Z80_WAITn, 1);
    chk("rst_timeout", rd_timeout, 0);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 60 && !req_seen; i++) @(negedge GPU_CLK);
    chk(name, req_seen, 1);
  endtask

  initial begin
    bit ok;
    tick(3);
    chk_reset();
    @(negedge GPU_CLK) reset = 1'b1;
    tick(4);

    // Single in-window write
    exp_wr.push_back({20'h00123, 8'h5A});
    waitn_low_seen = 1'b0;
    z80_write(22'h180123, 8'h5A, 1'b1, 1'b1, 1'b1);
    tick(6);
    chk("w1_waitn_low_seen", waitn_low_seen, 0);
    chk("w1_drained", exp_wr.size(), 0);

    // Write then read the same location
    exp_wr.push_back({20'h00010, 8'h33});
    exp_rd.push_back(20'h00010);
    exp_rdat.push_back(8'h33);
    z80_write(22'h180010, 8'h33, 1'b1, 1'b1, 1'b1);
    z80_read(22'h180010, ok);
    chk("raw_done", ok, 1);
    chk("raw_waitn", Z80_WAITn, 1);
    chk("raw_dir", Z80_245data_dir, 0);
    chk("raw_oe", Z80_245_oe, 1);
    z80_read_end();

    // Read with no GPU response
    gpu_auto = 1'b0;
    exp_rd.push_back(20'h00200);
    exp_rdat.push_back(8'hFF);
    z80_read(22'h180200, ok);
    chk("tmo_done", ok, 1);
    chk("tmo_len_ok", ((cyc - req_cyc) >= 255) && ((cyc - req_cyc) <= 260), 1);
    chk("tmo_flag", rd_timeout, 1);
    chk("tmo_waitn", Z80_WAITn, 1);
    z80_read_end();
    chk("tmo_sticky", rd_timeout, 1);

    // Five writes piled up behind a stalled read
    req_seen = 1'b0;
    exp_rd.push_back(20'h00300);
    exp_rdat.push_back(8'hA5);
    @(negedge GPU_CLK);
    Z80_addr = 22'h180300; Z80_MREQn = 1'b0; Z80_RDn = 1'b0;
    wait_req("stall_req_seen");
    for (int i = 0; i < 5; i++) begin
      exp_wr.push_back({20'h00400 + 20'(i), 8'hC0 + 8'(i)});
      z80_write(22'h180400 + 22'(i), 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    tick(4);
    chk("stall_no_drain", exp_wr.size(), 5);
    chk("stall_waitn", Z80_WAITn, 0);
    @(negedge GPU_CLK);
    rdat_man = 8'hA5; rdy_man = 1'b1;
    @(negedge GPU_CLK);
    rdy_man = 1'b0;
    wait_ena(20, ok);
    chk("stall_rd_done", ok, 1);
    tick(12);
    chk("stall_all_drained", exp_wr.size(), 0);
    z80_read_end();
    gpu_auto = 1'b1;

    // Outside the window: nothing may move
    oe_seen = 1'b0; waitn_low_seen = 1'b0; ena_seen = 1'b0;
    z80_write(22'h100000, 8'h77, 1'b1, 1'b0, 1'b1);
    @(negedge GPU_CLK);
    Z80_addr = 22'h100000; Z80_MREQn = 1'b0; Z80_RDn = 1'b0;
    tick(15);
    Z80_RDn = 1'b1; Z80_MREQn = 1'b1;
    tick(5);
    chk("out_oe_seen", oe_seen, 0);
    chk("out_waitn_low_seen", waitn_low_seen, 0);
    chk("out_ena_seen", ena_seen, 0);

    // Reset while waiting on the GPU, then a normal read
    gpu_auto = 1'b0;
    req_seen = 1'b0;
    exp_rd.push_back(20'h00500);
    @(negedge GPU_CLK);
    Z80_addr = 22'h180500; Z80_MREQn = 1'b0; Z80_RDn = 1'b0;
    wait_req("rst_req_seen");
    tick(5);
    chk("rst_pre_waitn", Z80_WAITn, 0);
    reset = 1'b0;
    #1;
    chk_reset();
    Z80_RDn = 1'b1; Z80_MREQn = 1'b1;
    tick(3);
    @(negedge GPU_CLK) reset = 1'b1;
    tick(4);
    gpu_auto = 1'b1;
    exp_rd.push_back(20'h00010);
    exp_rdat.push_back(8'h33);
    z80_read(22'h180010, ok);
    chk("post_rst_done", ok, 1);
    z80_read_end();

    tick(5);
    chk("queues_empty", exp_wr.size() + exp_rd.size() + exp_rdat.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
